triangle_scan_tx: RTL and testbench

- Initiator for the serial point-in-triangle tester interface (tester ports: x, y, reset, saida, disponivel).
- Latches one triangle and a rectangular bounding box, then raster-scans every pixel of the box.
- For each pixel it streams one 4-word frame to the tester: v1, v2, v3, pixel.
- Collects each tester verdict and re-emits it as a pixel/verdict stream with an inside counter. Sits between the scene/command logic and the tester instance.

---
 rtl/triangle_scan_tx_pkg.sv | 26 ++
 rtl/triangle_scan_tx_raster_counter.sv | 56 +++++
 rtl/triangle_scan_tx.sv | 176 +++++++++++++++++
 tb/tb_triangle_scan_tx.sv | 403 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/triangle_scan_tx_pkg.sv
// Shared constants and state encoding for the triangle scan initiator.
// Latency: n/a (definitions only).
// Backpressure: n/a (definitions only).
package triangle_scan_tx_pkg;

   localparam int W_DEF = 11;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      SYNC  = 3'd1,
      SEND  = 3'd2,
      DRAIN = 3'd3,
      DONE  = 3'd4
   } state_t;

   // Word positions inside one tester frame
   localparam logic [2:0] SLOT_V1   = 3'd0;
   localparam logic [2:0] SLOT_V2   = 3'd1;
   localparam logic [2:0] SLOT_V3   = 3'd2;
   localparam logic [2:0] SLOT_P    = 3'd3;
   localparam logic [2:0] SLOT_WAIT = 3'd4;

   localparam int FRAME_LEN     = 5;
   localparam int DRAIN_TIMEOUT = 4;

endpackage

// File: rtl/triangle_scan_tx_raster_counter.sv
// Raster position counter over an inclusive box, x inner and y outer.
// Latency: position updates one cycle after load/advance.
// Backpressure: none; the owner decides when to advance.
module triangle_scan_tx_raster_counter
   import triangle_scan_tx_pkg::*;
#(
   parameter int W = W_DEF
) (
   input  logic         CLOCK,
   input  logic         reset,
   input  logic         load,
   input  logic         advance,
   input  logic [W-1:0] x_min,
   input  logic [W-1:0] x_max,
   input  logic [W-1:0] y_min,
   input  logic [W-1:0] y_max,
   output logic [W-1:0] cx,
   output logic [W-1:0] cy,
   output logic         last
);

   logic [W-1:0] xl_min;
   logic [W-1:0] xl_max;
   logic [W-1:0] yl_max;
   logic [W:0]   nx;

   // x increment carries one extra bit so a box ending at 2^W-1 never wraps;
   // y needs no carry because the owner stops on last before y can overflow
   assign nx   = {1'b0, cx} + (W+1)'(1);
   assign last = (cx == xl_max) && (cy == yl_max);

   // Bounds are latched with the start position so the inputs may change mid-scan
   always_ff @(posedge CLOCK or negedge reset) begin
      if (!reset) begin
         cx     <= '0;
         cy     <= '0;
         xl_min <= '0;
         xl_max <= '0;
         yl_max <= '0;
      end else if (load) begin
         cx     <= x_min;
         cy     <= y_min;
         xl_min <= x_min;
         xl_max <= x_max;
         yl_max <= y_max;
      end else if (advance) begin
         if (nx > {1'b0, xl_max}) begin
            cx <= xl_min;
            cy <= cy + {{(W-1){1'b0}}, 1'b1};
         end else begin
            cx <= nx[W-1:0];
         end
      end
   end

endmodule

// File: rtl/triangle_scan_tx.sv
// Scans a box, sends one v1/v2/v3/pixel frame per pixel to the tester, reports verdicts.
// Latency: 5 cycles per pixel after a 1-cycle sync; verdict reported 1 cycle after disponivel.
// Backpressure: none; tester is paced open-loop, a missing final verdict times out after 4 cycles.
module triangle_scan_tx
   import triangle_scan_tx_pkg::*;
#(
   parameter int W  = W_DEF,
   parameter int CW = 2*W+1
) (
   input  logic          CLOCK,
   input  logic          reset,
   input  logic          start,
   input  logic [W-1:0]  v1x,
   input  logic [W-1:0]  v1y,
   input  logic [W-1:0]  v2x,
   input  logic [W-1:0]  v2y,
   input  logic [W-1:0]  v3x,
   input  logic [W-1:0]  v3y,
   input  logic [W-1:0]  bx_min,
   input  logic [W-1:0]  bx_max,
   input  logic [W-1:0]  by_min,
   input  logic [W-1:0]  by_max,
   output logic [W-1:0]  tst_x,
   output logic [W-1:0]  tst_y,
   output logic          tst_reset,
   input  logic          tst_saida,
   input  logic          tst_disponivel,
   output logic          pix_valid,
   output logic [W-1:0]  pix_x,
   output logic [W-1:0]  pix_y,
   output logic          pix_inside,
   output logic          busy,
   output logic          done,
   output logic [CW-1:0] inside_count
);

   state_t       state, state_n;
   logic [2:0]   slot, slot_n;
   logic [2:0]   tmo, tmo_n;
   logic [W-1:0] l1x, l1y, l2x, l2y, l3x, l3y;
   logic [W-1:0] fx, fy;
   logic [W-1:0] cx, cy;
   logic         last, load, advance;
   logic         accept, degen, capture;

   assign accept  = (state == IDLE) && start;
   assign degen   = (bx_min > bx_max) || (by_min > by_max);
   assign capture = tst_disponivel && ((state == SEND) || (state == DRAIN));

   triangle_scan_tx_raster_counter #(.W(W)) u_raster (
      .CLOCK   (CLOCK),
      .reset   (reset),
      .load    (load),
      .advance (advance),
      .x_min   (bx_min),
      .x_max   (bx_max),
      .y_min   (by_min),
      .y_max   (by_max),
      .cx      (cx),
      .cy      (cy),
      .last    (last)
   );

   // State, frame slot and drain timeout registers
   always_ff @(posedge CLOCK or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
         slot  <= SLOT_V1;
         tmo   <= '0;
      end else begin
         state <= state_n;
         slot  <= slot_n;
         tmo   <= tmo_n;
      end
   end

   // Triangle vertices held for the whole scan
   always_ff @(posedge CLOCK or negedge reset) begin
      if (!reset) begin
         {l1x, l1y, l2x, l2y, l3x, l3y} <= '0;
      end else if (accept) begin
         {l1x, l1y, l2x, l2y, l3x, l3y} <= {v1x, v1y, v2x, v2y, v3x, v3y};
      end
   end

   // Next-state logic and tester bus drive
   always_comb begin
      state_n   = state;
      slot_n    = slot;
      tmo_n     = tmo;
      tst_reset = 1'b1;
      tst_x     = '0;
      tst_y     = '0;
      busy      = 1'b0;
      done      = 1'b0;
      load      = 1'b0;
      advance   = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               load    = 1'b1;
               state_n = degen ? DONE : SYNC;
            end
         end
         SYNC: begin
            busy    = 1'b1;
            slot_n  = SLOT_V1;
            state_n = SEND;
         end
         SEND: begin
            busy      = 1'b1;
            tst_reset = 1'b0;
            case (slot)
               SLOT_V1: begin tst_x = l1x; tst_y = l1y; end
               SLOT_V2: begin tst_x = l2x; tst_y = l2y; end
               SLOT_V3: begin tst_x = l3x; tst_y = l3y; end
               default: begin tst_x = cx;  tst_y = cy;  end
            endcase
            if (slot == SLOT_WAIT) begin
               advance = 1'b1;
               slot_n  = SLOT_V1;
               if (last) begin
                  state_n = DRAIN;
                  tmo_n   = '0;
               end
            end else begin
               slot_n = slot + 3'd1;
            end
         end
         DRAIN: begin
            busy      = 1'b1;
            tst_reset = 1'b0;
            if (tst_disponivel || (tmo == 3'(DRAIN_TIMEOUT-1))) begin
               state_n = DONE;
            end else begin
               tmo_n = tmo + 3'd1;
            end
         end
         DONE: begin
            done    = 1'b1;
            state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

   // In-flight pixel and verdict capture; verdict k always lands before pixel k+1 is copied
   always_ff @(posedge CLOCK or negedge reset) begin
      if (!reset) begin
         fx           <= '0;
         fy           <= '0;
         pix_valid    <= 1'b0;
         pix_x        <= '0;
         pix_y        <= '0;
         pix_inside   <= 1'b0;
         inside_count <= '0;
      end else begin
         pix_valid <= 1'b0;
         if (accept) begin
            inside_count <= '0;
         end
         if ((state == SEND) && (slot == SLOT_P)) begin
            fx <= cx;
            fy <= cy;
         end
         if (capture) begin
            pix_valid    <= 1'b1;
            pix_x        <= fx;
            pix_y        <= fy;
            pix_inside   <= tst_saida;
            inside_count <= inside_count + CW'(tst_saida);
         end
      end
   end

endmodule

// File: tb/tb_triangle_scan_tx.sv
// Directed bench for triangle_scan_tx with a behavioural point-in-triangle tester.
// Latency: n/a.
// Backpressure: n/a.
module tb_triangle_scan_tx;

   localparam int W  = 11;
   localparam int CW = 2*W+1;

   logic          CLOCK = 1'b0;
   logic          reset;
   logic          start;
   logic [W-1:0]  v1x, v1y, v2x, v2y, v3x, v3y;
   logic [W-1:0]  bx_min, bx_max, by_min, by_max;
   logic [W-1:0]  tst_x, tst_y;
   logic          tst_reset, tst_saida, tst_disponivel;
   logic          pix_valid, pix_inside, busy, done;
   logic [W-1:0]  pix_x, pix_y;
   logic [CW-1:0] inside_count;

   int checks = 0;
   int errors = 0;

   triangle_scan_tx #(.W(W), .CW(CW)) dut (
      .CLOCK          (CLOCK),
      .reset          (reset),
      .start          (start),
      .v1x            (v1x),
      .v1y            (v1y),
      .v2x            (v2x),
      .v2y            (v2y),
      .v3x            (v3x),
      .v3y            (v3y),
      .bx_min         (bx_min),
      .bx_max         (bx_max),
      .by_min         (by_min),
      .by_max         (by_max),
      .tst_x          (tst_x),
      .tst_y          (tst_y),
      .tst_reset      (tst_reset),
      .tst_saida      (tst_saida),
      .tst_disponivel (tst_disponivel),
      .pix_valid      (pix_valid),
      .pix_x          (pix_x),
      .pix_y          (pix_y),
      .pix_inside     (pix_inside),
      .busy           (busy),
      .done           (done),
      .inside_count   (inside_count)
   );

   always #5 CLOCK = ~CLOCK;

   // Inclusive point-in-triangle by edge-function signs
   function automatic bit in_tri(input int ax, input int ay, input int bx, input int by,
                                 input int cx, input int cy, input int px, input int py);
      int d1, d2, d3;
      bit neg, pos;
      d1  = (px - bx) * (ay - by) - (ax - bx) * (py - by);
      d2  = (px - cx) * (by - cy) - (bx - cx) * (py - cy);
      d3  = (px - ax) * (cy - ay) - (cx - ax) * (py - ay);
      neg = (d1 < 0) || (d2 < 0) || (d3 < 0);
      pos = (d1 > 0) || (d2 > 0) || (d3 > 0);
      return !(neg && pos);
   endfunction

   // Behavioural tester: 4-word frame after sync, verdict two cycles after the pixel word
   int            mslot = 0;
   int            pend  = 0;
   bit            pend_v;
   bit            kill_last = 0;
   int            wx[4], wy[4];
   initial begin
      tst_disponivel = 1'b0;
      tst_saida      = 1'b0;
      forever begin
         @(negedge CLOCK);
         tst_disponivel = 1'b0;
         if (tst_reset) begin
            mslot = 0;
            pend  = 0;
         end else begin
            if (pend > 0) begin
               pend--;
               if (pend == 0) begin
                  tst_disponivel = 1'b1;
                  tst_saida      = pend_v;
               end
            end
            if (mslot < 4) begin
               wx[mslot] = int'(tst_x);
               wy[mslot] = int'(tst_y);
            end
            if (mslot == 3 && !(kill_last && wx[3] == 3 && wy[3] == 3)) begin
               pend_v = in_tri(wx[0], wy[0], wx[1], wy[1], wx[2], wy[2], wx[3], wy[3]);
               pend   = 2;
            end
            mslot = (mslot == 4) ? 0 : mslot + 1;
         end
      end
   end

   // Output monitor
   int cyc = 0;
   int done_cnt = 0;
   int done_cyc = 0;
   bit rst_low_seen = 0;
   int px_q[$], py_q[$], pin_q[$], pcyc_q[$], bx_q[$], by_q[$];
   initial begin
      forever begin
         @(negedge CLOCK);
         cyc++;
         if (pix_valid) begin
            px_q.push_back(int'(pix_x));
            py_q.push_back(int'(pix_y));
            pin_q.push_back(int'(pix_inside));
            pcyc_q.push_back(cyc);
         end
         if (done) begin
            done_cnt++;
            done_cyc = cyc;
         end
         if (!tst_reset) begin
            rst_low_seen = 1;
            bx_q.push_back(int'(tst_x));
            by_q.push_back(int'(tst_y));
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(negedge CLOCK);
      #1;
   endtask

   task automatic clear_log();
      px_q.delete(); py_q.delete(); pin_q.delete(); pcyc_q.delete();
      bx_q.delete(); by_q.delete();
      done_cnt     = 0;
      rst_low_seen = 0;
   endtask

   task automatic start_scan(input int ax, input int ay, input int bx, input int by,
                             input int cx, input int cy,
                             input int x0, input int x1, input int y0, input int y1);
      v1x = W'(ax); v1y = W'(ay); v2x = W'(bx); v2y = W'(by); v3x = W'(cx); v3y = W'(cy);
      bx_min = W'(x0); bx_max = W'(x1); by_min = W'(y0); by_max = W'(y1);
      start = 1'b1;
      step();
      start = 1'b0;
   endtask

   task automatic wait_done(input int maxc, input string nm);
      int n = 0;
      while (done_cnt == 0 && n < maxc) begin
         step();
         n++;
      end
      checks++;
      if (done_cnt == 0) begin
         errors++;
         $display("FAIL %s_done_timeout: no done within %0d cycles", nm, maxc);
      end
   endtask

   // Compares every reset-valued output against its required reset value
   task automatic check_reset_values(input string nm);
      int obs[9], exp_v[9];
      obs   = '{int'(tst_reset), int'(tst_x), int'(tst_y), int'(pix_valid), int'(pix_x),
                int'(pix_y), int'(busy), int'(done), int'(inside_count)};
      exp_v = '{1, 0, 0, 0, 0, 0, 0, 0, 0};
      for (int i = 0; i < 9; i++) begin
         checks++;
         if (obs[i] !== exp_v[i]) begin
            errors++;
            $display("FAIL %s_out%0d: got %0d expected %0d", nm, i, obs[i], exp_v[i]);
         end
      end
   endtask

   task automatic test_reset();
      start = 1'b0;
      {v1x, v1y, v2x, v2y, v3x, v3y} = '0;
      {bx_min, bx_max, by_min, by_max} = '0;
      reset = 1'b1;
      #2 reset = 1'b0;
      repeat (3) step();
      check_reset_values("reset");
      reset = 1'b1;
      step();
      step();
      check_reset_values("idle_after_reset");
   endtask

   task automatic test_single_pixel();
      int ex[5] = '{0, 20, 0, 5, 5};
      int ey[5] = '{0, 0, 20, 5, 5};
      clear_log();
      start_scan(0, 0, 20, 0, 0, 20, 5, 5, 5, 5);
      checks++;
      if (busy !== 1'b1) begin errors++; $display("FAIL single_busy: got %0b expected 1", busy); end
      wait_done(100, "single");
      step(); step();
      checks++;
      if (bx_q.size() < 5) begin
         errors++;
         $display("FAIL single_bus_len: got %0d words expected at least 5", bx_q.size());
      end else begin
         for (int i = 0; i < 5; i++) begin
            checks++;
            if (bx_q[i] !== ex[i] || by_q[i] !== ey[i]) begin
               errors++;
               $display("FAIL single_bus%0d: got (%0d,%0d) expected (%0d,%0d)",
                        i, bx_q[i], by_q[i], ex[i], ey[i]);
            end
         end
      end
      checks++;
      if (px_q.size() !== 1) begin
         errors++;
         $display("FAIL single_pix_count: got %0d expected 1", px_q.size());
      end else begin
         checks++;
         if (px_q[0] !== 5 || py_q[0] !== 5 || pin_q[0] !== 1) begin
            errors++;
            $display("FAIL single_pix: got (%0d,%0d,in=%0d) expected (5,5,in=1)",
                     px_q[0], py_q[0], pin_q[0]);
         end
         checks++;
         if (done_cyc - pcyc_q[0] < 0 || done_cyc - pcyc_q[0] > 1) begin
            errors++;
            $display("FAIL single_done_delay: got %0d cycles expected 0..1", done_cyc - pcyc_q[0]);
         end
      end
      checks++;
      if (busy !== 1'b0 || inside_count !== CW'(1)) begin
         errors++;
         $display("FAIL single_end: got busy=%0b count=%0d expected busy=0 count=1", busy, inside_count);
      end
   endtask

   // Full 4x4 raster; pinside given either by the reference model or by x+y<=3
   task automatic scan_4x4(input string nm, input bit small_tri, input int exp_count);
      int ones = 0;
      bit exp_in;
      clear_log();
      if (small_tri) start_scan(0, 0, 3, 0, 0, 3, 0, 3, 0, 3);
      else           start_scan(0, 0, 20, 0, 0, 20, 0, 3, 0, 3);
      wait_done(300, nm);
      step(); step();
      checks++;
      if (px_q.size() !== 16) begin
         errors++;
         $display("FAIL %s_pix_count: got %0d expected 16", nm, px_q.size());
      end else begin
         for (int i = 0; i < 16; i++) begin
            exp_in = small_tri ? ((i % 4) + (i / 4) <= 3) : 1'b1;
            ones += pin_q[i];
            checks++;
            if (px_q[i] !== i % 4 || py_q[i] !== i / 4 || pin_q[i] !== int'(exp_in)) begin
               errors++;
               $display("FAIL %s_pix%0d: got (%0d,%0d,in=%0d) expected (%0d,%0d,in=%0d)",
                        nm, i, px_q[i], py_q[i], pin_q[i], i % 4, i / 4, exp_in);
            end
            if (i > 0) begin
               checks++;
               if (pcyc_q[i] - pcyc_q[i-1] !== 5) begin
                  errors++;
                  $display("FAIL %s_spacing%0d: got %0d expected 5", nm, i, pcyc_q[i] - pcyc_q[i-1]);
               end
            end
         end
         checks++;
         if (int'(inside_count) !== ones) begin
            errors++;
            $display("FAIL %s_count_vs_pulses: got %0d expected %0d", nm, inside_count, ones);
         end
      end
      checks++;
      if (int'(inside_count) !== exp_count) begin
         errors++;
         $display("FAIL %s_inside_count: got %0d expected %0d", nm, inside_count, exp_count);
      end
   endtask

   task automatic test_degenerate();
      clear_log();
      start_scan(0, 0, 20, 0, 0, 20, 7, 6, 0, 0);
      wait_done(1, "degenerate");
      repeat (3) step();
      checks++;
      if (px_q.size() !== 0 || rst_low_seen !== 0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL degenerate: got pix=%0d tst_reset_low=%0b busy=%0b expected 0,0,0",
                  px_q.size(), rst_low_seen, busy);
      end
   endtask

   task automatic test_edge_box();
      clear_log();
      start_scan(0, 0, 20, 0, 0, 20, 2046, 2047, 0, 0);
      wait_done(100, "edge");
      step(); step();
      checks++;
      if (px_q.size() !== 2) begin
         errors++;
         $display("FAIL edge_pix_count: got %0d expected 2", px_q.size());
      end else begin
         for (int i = 0; i < 2; i++) begin
            checks++;
            if (px_q[i] !== 2046 + i || py_q[i] !== 0 || pin_q[i] !== 0) begin
               errors++;
               $display("FAIL edge_pix%0d: got (%0d,%0d,in=%0d) expected (%0d,0,in=0)",
                        i, px_q[i], py_q[i], pin_q[i], 2046 + i);
            end
         end
      end
      checks++;
      if (done_cnt !== 1 || inside_count !== '0) begin
         errors++;
         $display("FAIL edge_end: got done=%0d count=%0d expected 1,0", done_cnt, inside_count);
      end
   endtask

   task automatic test_reset_mid();
      int n = 0;
      clear_log();
      start_scan(0, 0, 20, 0, 0, 20, 0, 3, 0, 3);
      while (px_q.size() < 3 && n < 200) begin step(); n++; end
      checks++;
      if (px_q.size() < 3) begin
         errors++;
         $display("FAIL midreset_reach: got %0d pixels expected 3", px_q.size());
      end
      #2 reset = 1'b0;
      #1;
      check_reset_values("midreset");
      done_cnt = 0;
      repeat (3) step();
      checks++;
      if (done_cnt !== 0 || tst_reset !== 1'b1) begin
         errors++;
         $display("FAIL midreset_hold: got done=%0d tst_reset=%0b expected 0,1", done_cnt, tst_reset);
      end
      reset = 1'b1;
      step();
      scan_4x4("rescan", 1'b0, 16);
   endtask

   task automatic test_restart_timeout();
      clear_log();
      kill_last = 1;
      start_scan(0, 0, 20, 0, 0, 20, 0, 3, 0, 3);
      repeat (10) step();
      start_scan(0, 0, 20, 0, 0, 20, 10, 12, 10, 12);
      wait_done(300, "timeout");
      kill_last = 0;
      repeat (4) step();
      checks++;
      if (px_q.size() !== 15) begin
         errors++;
         $display("FAIL timeout_pix_count: got %0d expected 15", px_q.size());
      end else begin
         for (int i = 0; i < 15; i++) begin
            checks++;
            if (px_q[i] !== i % 4 || py_q[i] !== i / 4) begin
               errors++;
               $display("FAIL timeout_pix%0d: got (%0d,%0d) expected (%0d,%0d)",
                        i, px_q[i], py_q[i], i % 4, i / 4);
            end
         end
         checks++;
         if (done_cyc - pcyc_q[14] !== 8) begin
            errors++;
            $display("FAIL timeout_done_gap: got %0d expected 8", done_cyc - pcyc_q[14]);
         end
      end
      checks++;
      if (done_cnt !== 1 || inside_count !== CW'(15)) begin
         errors++;
         $display("FAIL timeout_end: got done=%0d count=%0d expected 1,15", done_cnt, inside_count);
      end
   endtask

   initial begin
      test_reset();
      test_single_pixel();
      scan_4x4("box4", 1'b0, 16);
      scan_4x4("smalltri", 1'b1, 10);
      test_degenerate();
      test_edge_box();
      test_reset_mid();
      test_restart_timeout();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
